// File: rtl/piezo_pkg.sv
// Shared widths, defaults and state type for the piezo tone driver.
package piezo_pkg;

  localparam int unsigned PER_W         = 15;
  localparam int unsigned DUR_W         = 8;
  localparam int unsigned TICK_CLKS_DEF = 500000;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } drv_state_t;

  // A zero duration plays for one tick.
  function automatic logic [DUR_W-1:0] dur_target(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? DUR_W'(1) : dur;
  endfunction

endpackage

// File: rtl/piezo_tick_gen.sv
// Duration-tick prescaler: counts 0..TICK_CLKS-1 and flags the terminal count.
module piezo_tick_gen
  import piezo_pkg::*;
#(
  parameter int unsigned TICK_CLKS = TICK_CLKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned       CNT_W = 19;
  localparam logic [CNT_W-1:0]  TERM  = CNT_W'(TICK_CLKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/piezo_drv.sv
// Piezo tone driver: differential square wave of note_per clks for note_dur
// duration ticks, then a one-clk note_over pulse; clr holds it silent.
module piezo_drv
  import piezo_pkg::*;
#(
  parameter int unsigned TICK_CLKS = TICK_CLKS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [PER_W-1:0] note_per,
  input  logic [DUR_W-1:0] note_dur,
  output logic             piezo,
  output logic             piezo_n,
  output logic             note_over
);

  drv_state_t       state_q, state_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
  logic             piezo_q, piezo_d;
  logic             piezo_n_q, piezo_n_d;
  logic             note_over_q, note_over_d;

  logic             tick;
  logic             restart;
  logic             active;
  logic             audible;
  logic             hi_phase;
  logic [DUR_W:0]   dur_inc;

  // Counters are zero on the first PLAY clk and on the clk after each pulse.
  assign restart  = clr || (state_q == IDLE) || note_over_q;
  assign active   = !clr && (state_q == PLAY);
  assign audible  = (note_per >= PER_W'(2));
  assign hi_phase = (per_cnt_q < (note_per >> 1));
  assign dur_inc  = {1'b0, dur_cnt_q} + (DUR_W+1)'(1);

  piezo_tick_gen #(
    .TICK_CLKS(TICK_CLKS)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (restart),
    .tick (tick)
  );

  always_comb begin
    state_d     = clr ? IDLE : PLAY;
    per_cnt_d   = per_cnt_q;
    dur_cnt_d   = dur_cnt_q;
    piezo_d     = 1'b0;
    piezo_n_d   = 1'b0;
    note_over_d = 1'b0;

    if (restart) begin
      per_cnt_d = '0;
      dur_cnt_d = '0;
    end else begin
      if ((note_per == '0) || (per_cnt_q >= note_per - PER_W'(1))) per_cnt_d = '0;
      else                                                          per_cnt_d = per_cnt_q + PER_W'(1);
      if (tick) dur_cnt_d = dur_inc[DUR_W-1:0];
    end

    if (active) begin
      piezo_d     = audible && hi_phase;
      piezo_n_d   = audible && !hi_phase;
      note_over_d = !note_over_q && tick && (dur_inc == {1'b0, dur_target(note_dur)});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      dur_cnt_q   <= '0;
      piezo_q     <= 1'b0;
      piezo_n_q   <= 1'b0;
      note_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      dur_cnt_q   <= dur_cnt_d;
      piezo_q     <= piezo_d;
      piezo_n_q   <= piezo_n_d;
      note_over_q <= note_over_d;
    end
  end

  assign piezo     = piezo_q;
  assign piezo_n   = piezo_n_q;
  assign note_over = note_over_q;

endmodule

// File: tb/tb_piezo_drv.sv
// Self-checking bench for piezo_drv against a note-timeline reference model.
module tb_piezo_drv;
  import piezo_pkg::*;

  localparam int unsigned TCK = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b1;
  logic [PER_W-1:0] note_per = '0;
  logic [DUR_W-1:0] note_dur = '0;
  logic             piezo, piezo_n, note_over;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: whether the block is playing, and clks elapsed since first PLAY clk.
  bit          m_play = 1'b0;
  int unsigned m_k    = 0;

  piezo_drv #(
    .TICK_CLKS(TCK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .note_per (note_per),
    .note_dur (note_dur),
    .piezo    (piezo),
    .piezo_n  (piezo_n),
    .note_over(note_over)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Each note spans L+1 clks (L = duration in clks, plus the pulse clk);
  // the tone phase runs continuously from 0 across that span.
  function automatic logic [2:0] model_out();
    int unsigned n, d, l, j, ph;
    bit hi;
    n = note_per;
    d = (note_dur == 0) ? 1 : note_dur;
    l = d * TCK;
    if (!m_play || m_k == 0) return 3'b000;
    j  = m_k % (l + 1);
    ph = ((j == 0) ? l : j - 1) % ((n == 0) ? 1 : n);
    hi = (ph < n / 2);
    return {(n >= 2) && hi, (n >= 2) && !hi, j == l};
  endfunction

  task automatic step();
    logic [2:0] e;
    @(posedge clk);
    if (!rst_n || clr)  m_play = 1'b0;
    else if (!m_play) begin m_play = 1'b1; m_k = 0; end
    else                m_k++;
    @(negedge clk);
    e = model_out();
    check_val("piezo",     32'(piezo),     32'(e[2]));
    check_val("piezo_n",   32'(piezo_n),   32'(e[1]));
    check_val("note_over", 32'(note_over), 32'(e[0]));
  endtask

  task automatic start_note(input logic [PER_W-1:0] per, input logic [DUR_W-1:0] dur);
    clr = 1'b1; note_per = per; note_dur = dur;
    step();
    clr = 1'b0;
  endtask

  task automatic wait_over(input string tag, input int unsigned exp);
    int unsigned c = 0;
    do begin step(); c++; end while (!note_over && c < 5000);
    check_val(tag, c, exp);
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Basic tone, two back-to-back notes
    start_note(15'd8, 8'd3);
    wait_over("lat_note1", 31);
    wait_over("lat_note2", 31);
    repeat (10) step();

    // Rest note
    start_note(15'd0, 8'd2);
    wait_over("lat_rest", 21);
    repeat (5) step();

    // Zero duration behaves as one tick
    start_note(15'd6, 8'd0);
    wait_over("lat_dur0", 11);
    start_note(15'd6, 8'd1);
    wait_over("lat_dur1", 11);

    // clr mid-note, then a full note from scratch
    start_note(15'd8, 8'd3);
    repeat (16) step();
    clr = 1'b1;
    step();
    check_val("clr_piezo", 32'(piezo | piezo_n | note_over), 32'd0);
    repeat (3) step();
    clr = 1'b0;
    wait_over("lat_after_clr", 31);

    // clr coinciding with the would-be pulse suppresses it
    start_note(15'd8, 8'd3);
    repeat (30) step();
    clr = 1'b1;
    step();
    check_val("clr_vs_over", 32'(note_over), 32'd0);
    clr = 1'b0;

    // Asynchronous reset mid-note
    start_note(15'd8, 8'd3);
    repeat (13) step();
    #2 rst_n = 1'b0;
    #1 check_val("rst_async", 32'({piezo, piezo_n, note_over}), 32'd0);
    m_play = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    start_note(15'd8, 8'd3);
    wait_over("lat_after_rst", 31);

    // Large period and long duration
    start_note(15'h7C90, 8'h40);
    wait_over("lat_long", 641);
    repeat (20) step();
    start_note(15'd5, 8'd255);
    wait_over("lat_dur255", 2551);

    // Randomized notes with occasional clr glitches
    for (int i = 0; i < 14; i++) begin
      int unsigned cyc;
      start_note(15'($urandom_range(0, 24)), 8'($urandom_range(0, 4)));
      cyc = $urandom_range(30, 160);
      for (int c = 0; c < int'(cyc); c++) begin
        clr = ($urandom_range(0, 39) == 0);
        step();
      end
      clr = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
